// File: rtl/axis_ms_mtr_loopback_gen.sv
// Master-side loopback test generator/checker on a 32-bit AXI-Stream datapath.
// TX emits numbered Ethernet test frames; RX checks frames returned by the far-end
// loopback, optionally with DST/SRC swapped, and keeps frame and error counters.
`timescale 1ns/1ps
module axis_ms_mtr_loopback_gen #(
  parameter logic [47:0] DST_MAC     = 48'h0A_35_00_01_02_03,
  parameter logic [47:0] SRC_MAC     = 48'h0A_35_00_04_05_06,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int unsigned FRAME_WORDS = 16,
  parameter int unsigned IFG_CYCLES  = 12
) (
  input  logic        axis_clk,
  input  logic        axis_reset,
  input  logic        mtrlb_en,
  input  logic        mtrlb_expect_swap,
  output logic [31:0] m_axis_mtrlb_d_tdata,
  output logic [3:0]  m_axis_mtrlb_d_tkeep,
  output logic        m_axis_mtrlb_d_tvalid,
  output logic        m_axis_mtrlb_d_tlast,
  output logic        m_axis_mtrlb_d_tuser,
  input  logic        m_axis_mtrlb_d_tready,
  input  logic [31:0] s_axis_mtrlb_d_tdata,
  input  logic [3:0]  s_axis_mtrlb_d_tkeep,
  input  logic        s_axis_mtrlb_d_tvalid,
  input  logic        s_axis_mtrlb_d_tlast,
  input  logic        s_axis_mtrlb_d_tuser,
  output logic        s_axis_mtrlb_d_tready,
  output logic [31:0] frames_tx_count,
  output logic [31:0] frames_rx_count,
  output logic [15:0] err_count,
  output logic        mtrlb_activity_flash
);

  // Word index must be able to hold FRAME_WORDS itself (RX saturation value).
  localparam int unsigned WW = $clog2(FRAME_WORDS + 1);
  localparam int unsigned CW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;
  localparam logic [WW-1:0] LastW = WW'(FRAME_WORDS - 1);
  localparam logic [WW-1:0] MaxW  = WW'(FRAME_WORDS);
  localparam logic [WW-1:0] SeqW  = WW'(3);

  // Expected content of word w; byte 0 sits in [7:0], fields in network order.
  function automatic logic [31:0] frame_word(input logic [WW-1:0] w, input logic [15:0] seq,
                                             input logic swap);
    logic [47:0] a;
    logic [47:0] b;
    logic [7:0]  base;
    a    = swap ? SRC_MAC : DST_MAC;
    b    = swap ? DST_MAC : SRC_MAC;
    base = 8'({w, 2'b00});
    if (w == WW'(0)) begin
      return {a[23:16], a[31:24], a[39:32], a[47:40]};
    end else if (w == WW'(1)) begin
      return {b[39:32], b[47:40], a[7:0], a[15:8]};
    end else if (w == WW'(2)) begin
      return {b[7:0], b[15:8], b[23:16], b[31:24]};
    end else if (w == SeqW) begin
      return {seq[7:0], seq[15:8], ETHERTYPE[7:0], ETHERTYPE[15:8]};
    end else begin
      return {base + 8'd3, base + 8'd2, base + 8'd1, base};
    end
  endfunction

  // ---------------------------------------------------------------- TX side
  typedef enum logic [1:0] {StIdle, StSend, StIfg} tx_state_e;

  tx_state_e      state_q, state_d;
  logic [WW-1:0]  tx_w_q, tx_w_d;
  logic [15:0]    tx_seq_q, tx_seq_d;
  logic [CW-1:0]  ifg_q, ifg_d;
  logic [31:0]    tx_cnt_q, tx_cnt_d;
  logic           tx_send;

  // TX state register.
  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      state_q  <= StIdle;
      tx_w_q   <= '0;
      tx_seq_q <= '0;
      ifg_q    <= '0;
      tx_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      tx_w_q   <= tx_w_d;
      tx_seq_q <= tx_seq_d;
      ifg_q    <= ifg_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  // TX next-state: idle -> send frame -> inter-frame gap -> send or idle.
  always_comb begin
    state_d  = state_q;
    tx_w_d   = tx_w_q;
    tx_seq_d = tx_seq_q;
    ifg_d    = ifg_q;
    tx_cnt_d = tx_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mtrlb_en) begin
          state_d = StSend;
          tx_w_d  = '0;
        end
      end
      StSend: begin
        if (m_axis_mtrlb_d_tready) begin
          if (tx_w_q == LastW) begin
            tx_seq_d = tx_seq_q + 16'd1;
            tx_cnt_d = tx_cnt_q + 32'd1;
            ifg_d    = CW'(IFG_CYCLES);
            state_d  = StIfg;
          end else begin
            tx_w_d = tx_w_q + WW'(1);
          end
        end
      end
      StIfg: begin
        // Leaving at 1 gives exactly IFG_CYCLES idle cycles; 0 still costs one cycle.
        if (ifg_q <= CW'(1)) begin
          tx_w_d  = '0;
          state_d = mtrlb_en ? StSend : StIdle;
        end else begin
          ifg_d = ifg_q - CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // TX outputs decoded from registered state; data is zero whenever tvalid is low.
  always_comb begin
    tx_send               = (state_q == StSend);
    m_axis_mtrlb_d_tvalid = tx_send;
    m_axis_mtrlb_d_tdata  = tx_send ? frame_word(tx_w_q, tx_seq_q, 1'b0) : 32'h0;
    m_axis_mtrlb_d_tkeep  = tx_send ? 4'hF : 4'h0;
    m_axis_mtrlb_d_tlast  = tx_send && (tx_w_q == LastW);
    m_axis_mtrlb_d_tuser  = 1'b0;
  end

  // ---------------------------------------------------------------- RX side
  logic          rdy_q;
  logic [WW-1:0] rx_w_q, rx_w_d;
  logic          ferr_q, ferr_d;
  logic [15:0]   exp_seq_q, exp_seq_d;
  logic [15:0]   rx_seq_q, rx_seq_d;
  logic [31:0]   rx_cnt_q, rx_cnt_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic          beat, beat_err;
  logic [15:0]   recv_seq, seq_src;

  // RX state register; tready comes up the first cycle out of reset.
  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      rdy_q     <= 1'b0;
      rx_w_q    <= '0;
      ferr_q    <= 1'b0;
      exp_seq_q <= '0;
      rx_seq_q  <= '0;
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      rdy_q     <= 1'b1;
      rx_w_q    <= rx_w_d;
      ferr_q    <= ferr_d;
      exp_seq_q <= exp_seq_d;
      rx_seq_q  <= rx_seq_d;
      rx_cnt_q  <= rx_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // RX beat checking and per-frame accounting.
  always_comb begin
    rx_w_d    = rx_w_q;
    ferr_d    = ferr_q;
    exp_seq_d = exp_seq_q;
    rx_seq_d  = rx_seq_q;
    rx_cnt_d  = rx_cnt_q;
    err_cnt_d = err_cnt_q;
    beat      = s_axis_mtrlb_d_tvalid && rdy_q;
    recv_seq  = {s_axis_mtrlb_d_tdata[23:16], s_axis_mtrlb_d_tdata[31:24]};
    beat_err  = 1'b0;

    if (rx_w_q >= MaxW) begin
      beat_err = 1'b1;
    end else if (rx_w_q == SeqW) begin
      beat_err = (s_axis_mtrlb_d_tdata[15:0] != {ETHERTYPE[7:0], ETHERTYPE[15:8]}) ||
                 (recv_seq != exp_seq_q);
    end else begin
      beat_err = s_axis_mtrlb_d_tdata != frame_word(rx_w_q, exp_seq_q, mtrlb_expect_swap);
    end
    if (s_axis_mtrlb_d_tkeep != 4'hF) beat_err = 1'b1;
    if (s_axis_mtrlb_d_tlast && (rx_w_q != LastW)) beat_err = 1'b1;
    if (s_axis_mtrlb_d_tlast && s_axis_mtrlb_d_tuser) beat_err = 1'b1;

    // Sequence reference re-syncs to what was received, so one loss costs one error.
    seq_src = (rx_w_q == SeqW) ? recv_seq : rx_seq_q;

    if (beat) begin
      if (s_axis_mtrlb_d_tlast) begin
        rx_cnt_d = rx_cnt_q + 32'd1;
        if ((ferr_q || beat_err) && (err_cnt_q != 16'hFFFF)) begin
          err_cnt_d = err_cnt_q + 16'd1;
        end
        ferr_d    = 1'b0;
        rx_w_d    = '0;
        exp_seq_d = seq_src + 16'd1;
        rx_seq_d  = seq_src + 16'd1;
      end else begin
        ferr_d = ferr_q || beat_err;
        if (rx_w_q != MaxW) rx_w_d = rx_w_q + WW'(1);
        if (rx_w_q == SeqW) rx_seq_d = recv_seq;
      end
    end
  end

  assign s_axis_mtrlb_d_tready = rdy_q;
  assign frames_tx_count       = tx_cnt_q;
  assign frames_rx_count       = rx_cnt_q;
  assign err_count             = err_cnt_q;
  assign mtrlb_activity_flash  = rx_cnt_q[13];

endmodule

// File: tb/tb_axis_ms_mtr_loopback_gen.sv
// Bench for axis_ms_mtr_loopback_gen: TX checked beat by beat against a byte-level frame
// model, TX looped back to RX through a swap/corrupt/drop path, plus directly driven
// malformed RX frames and a mid-frame reset.
`timescale 1ns/1ps
module tb_axis_ms_mtr_loopback_gen;
  localparam logic [47:0] DST = 48'h0A_35_00_01_02_03;
  localparam logic [47:0] SRC = 48'h0A_35_00_04_05_06;
  localparam logic [15:0] ETH = 16'h88B5;
  localparam int FW  = 16;
  localparam int IFG = 12;

  logic        clk = 1'b0;
  logic        rst, m_en, expect_swap;
  logic [31:0] m_tdata, s_tdata, d_tdata;
  logic [3:0]  m_tkeep, s_tkeep, d_tkeep;
  logic        m_tvalid, m_tlast, m_tuser, m_tready;
  logic        s_tvalid, s_tlast, s_tuser, s_tready;
  logic        d_tvalid, d_tlast, d_tuser;
  logic [31:0] tx_count, rx_count;
  logic [15:0] err_count;
  logic        flash;

  int vectors = 0, miscompares = 0;
  int tx_w = 0, tx_f = 0, stop_f = -1, drop_f = -1, corrupt_f = -1;
  int idle_cnt = 0, exp_tx = 0, exp_rx = 0, exp_err = 0;
  logic [15:0] tx_seq_m = 16'h0;
  bit lb, swap_model, stalled = 0, gap_armed = 0;
  logic [31:0] held_d, cap_w0, cap_w3;
  logic        held_l;

  always #5 clk = ~clk;

  axis_ms_mtr_loopback_gen dut (
    .axis_clk              (clk),
    .axis_reset            (rst),
    .mtrlb_en              (m_en),
    .mtrlb_expect_swap     (expect_swap),
    .m_axis_mtrlb_d_tdata  (m_tdata),
    .m_axis_mtrlb_d_tkeep  (m_tkeep),
    .m_axis_mtrlb_d_tvalid (m_tvalid),
    .m_axis_mtrlb_d_tlast  (m_tlast),
    .m_axis_mtrlb_d_tuser  (m_tuser),
    .m_axis_mtrlb_d_tready (m_tready),
    .s_axis_mtrlb_d_tdata  (s_tdata),
    .s_axis_mtrlb_d_tkeep  (s_tkeep),
    .s_axis_mtrlb_d_tvalid (s_tvalid),
    .s_axis_mtrlb_d_tlast  (s_tlast),
    .s_axis_mtrlb_d_tuser  (s_tuser),
    .s_axis_mtrlb_d_tready (s_tready),
    .frames_tx_count       (tx_count),
    .frames_rx_count       (rx_count),
    .err_count             (err_count),
    .mtrlb_activity_flash  (flash)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame as a flat byte sequence: DST, SRC, EtherType, seq, then (index mod 256).
  function automatic logic [7:0] fbyte(input int i, input logic [15:0] seq, input bit swap);
    logic [47:0] a, b;
    a = swap ? SRC : DST;
    b = swap ? DST : SRC;
    if (i < 6)   return a[47 - 8*i -: 8];
    if (i < 12)  return b[47 - 8*(i-6) -: 8];
    if (i == 12) return ETH[15:8];
    if (i == 13) return ETH[7:0];
    if (i == 14) return seq[15:8];
    if (i == 15) return seq[7:0];
    return 8'(i % 256);
  endfunction

  function automatic logic [31:0] fword(input int w, input logic [15:0] seq, input bit swap);
    return {fbyte(4*w+3, seq, swap), fbyte(4*w+2, seq, swap),
            fbyte(4*w+1, seq, swap), fbyte(4*w, seq, swap)};
  endfunction

  // Return path: far-end loopback model (swap, corrupt, drop) or direct drive.
  always_comb begin
    s_tdata  = d_tdata;
    s_tkeep  = d_tkeep;
    s_tvalid = d_tvalid;
    s_tlast  = d_tlast;
    s_tuser  = d_tuser;
    if (lb) begin
      s_tvalid = m_tvalid && m_tready && (tx_f != drop_f);
      s_tdata  = (swap_model && tx_w < 3) ? fword(tx_w, 16'h0, 1'b1) : m_tdata;
      if (tx_f == corrupt_f && tx_w == 6) s_tdata = s_tdata ^ 32'h0000_0100;
      s_tkeep  = m_tkeep;
      s_tlast  = m_tlast;
      s_tuser  = m_tuser;
    end
  end

  // One clock: drive tready, check the TX beat, then advance the reference position.
  task automatic step(input bit bp);
    bit hs = 0;
    @(negedge clk);
    m_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    if (m_tvalid) begin
      if (stalled) begin
        chk("stall_data", m_tdata, held_d);
        chk("stall_last", 32'(m_tlast), 32'(held_l));
      end
      if (gap_armed) begin
        chk("ifg_gap", idle_cnt, IFG);
        gap_armed = 0;
      end
      if (m_tready) begin
        chk("tx_data", m_tdata, fword(tx_w, tx_seq_m, 1'b0));
        chk("tx_last", 32'(m_tlast), 32'(tx_w == FW - 1));
        chk("tx_keep", 32'(m_tkeep), 32'hF);
        chk("tx_user", 32'(m_tuser), 32'h0);
        if (tx_seq_m == 16'h0 && tx_w == 0) cap_w0 = m_tdata;
        if (tx_seq_m == 16'h0 && tx_w == 3) cap_w3 = m_tdata;
        hs = 1;
        stalled = 0;
      end else begin
        stalled = 1;
        held_d  = m_tdata;
        held_l  = m_tlast;
      end
    end else begin
      idle_cnt++;
    end
    @(posedge clk);
    #1;
    if (hs) begin
      if (tx_w == FW - 1) begin
        tx_w = 0;
        tx_seq_m++;
        tx_f++;
        idle_cnt = 0;
        gap_armed = m_en;
      end else begin
        tx_w++;
      end
      if (tx_f == stop_f && tx_w > 0) m_en = 1'b0;
    end
  endtask

  // Send n frames with en held until the last one starts, then drain.
  task automatic run_frames(input int n, input bit bp);
    int start = tx_f;
    int cyc = 0;
    stop_f = start + n - 1;
    m_en = 1'b1;
    while (tx_f < start + n && cyc < n * 120 + 100) begin
      step(bp);
      cyc++;
    end
    chk("frames_done", tx_f - start, n);
    repeat (20) step(bp);
    chk("tx_no_extra", tx_f - start, n);
    chk("tx_idle_word", tx_w, 0);
    exp_tx += n;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_tx"}, tx_count, exp_tx);
    chk({tag, "_rx"}, rx_count, exp_rx);
    chk({tag, "_err"}, 32'(err_count), exp_err);
  endtask

  task automatic send_rx(input int nw, input logic [15:0] seq, input bit usr);
    for (int i = 0; i < nw; i++) begin
      @(negedge clk);
      d_tvalid = 1'b1;
      d_tdata  = fword(i, seq, 1'b0);
      d_tkeep  = 4'hF;
      d_tlast  = (i == nw - 1);
      d_tuser  = usr && (i == nw - 1);
    end
    @(negedge clk);
    d_tvalid = 1'b0;
    d_tlast  = 1'b0;
    d_tuser  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1; m_en = 1'b0; expect_swap = 1'b0; m_tready = 1'b0;
    lb = 1; swap_model = 0;
    d_tvalid = 1'b0; d_tdata = '0; d_tkeep = '0; d_tlast = 1'b0; d_tuser = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(m_tvalid), 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tkeep", 32'(m_tkeep), 0);
    chk("rst_tlast", 32'(m_tlast), 0);
    chk("rst_tready", 32'(s_tready), 0);
    chk("rst_flash", 32'(flash), 0);
    check_counts("rst");
    rst = 1'b0;

    // Single frame, no backpressure, plain loopback.
    run_frames(1, 0);
    exp_rx = 1;
    check_counts("single");
    chk("w0_const", cap_w0, 32'h0100350A);
    chk("w3_const", cap_w3, 32'h0000B588);

    // 100 frames with 50% backpressure through a swapping loopback.
    expect_swap = 1'b1; swap_model = 1;
    run_frames(100, 1);
    exp_rx += 100;
    check_counts("swap100");

    // No swap; one payload byte corrupted in the fifth frame.
    expect_swap = 1'b0; swap_model = 0;
    corrupt_f = tx_f + 4;
    run_frames(10, 1);
    corrupt_f = -1;
    exp_rx += 10; exp_err += 1;
    check_counts("corrupt");

    // Third frame lost on the return path: next frame's sequence is flagged once.
    drop_f = tx_f + 2;
    run_frames(8, 0);
    drop_f = -1;
    exp_rx += 7; exp_err += 1;
    check_counts("drop");

    // Directly driven frames: truncated, tuser on last, then clean.
    lb = 0;
    send_rx(10, tx_seq_m, 1'b0);
    exp_rx += 1; exp_err += 1;
    check_counts("trunc");
    send_rx(FW, tx_seq_m + 16'd1, 1'b1);
    exp_rx += 1; exp_err += 1;
    check_counts("tuser");
    send_rx(FW, tx_seq_m + 16'd2, 1'b0);
    exp_rx += 1;
    check_counts("clean");
    chk("flash", 32'(flash), 32'(exp_rx >> 13) & 32'h1);

    // Reset in the middle of a looped frame.
    lb = 1;
    m_en = 1'b1;
    stop_f = -1;
    cyc = 0;
    while (tx_w != 5 && cyc < 200) begin
      step(0);
      cyc++;
    end
    chk("mid_frame_reached", tx_w, 5);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_tx = 0; exp_rx = 0; exp_err = 0;
    chk("mrst_tvalid", 32'(m_tvalid), 0);
    chk("mrst_tready", 32'(s_tready), 0);
    check_counts("mrst");
    tx_w = 0; tx_seq_m = 16'h0; stalled = 0; gap_armed = 0; idle_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    run_frames(1, 0);
    exp_rx = 1;
    check_counts("post_rst");
    chk("post_rst_w3", cap_w3, 32'h0000B588);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_ms_mtr_loopback_gen.md
Name: axis_ms_mtr_loopback_gen

Overview:
- Master-side counterpart of the slave loopback path: generates numbered Ethernet test frames on an AXI-Stream master port and checks the frames returned by the far-end slave loopback on an AXI-Stream slave port.
- Optional L2 address swap is expected on the returned frames.
- Sits beside the slave loopback block on the 32-bit AXIS datapath.
- Exposes frame and error counters plus an activity flash.

Parameters:
- DST_MAC, 48'h0A_35_00_01_02_03, destination MAC inserted in TX frames.
- SRC_MAC, 48'h0A_35_00_04_05_06, source MAC inserted in TX frames.
- ETHERTYPE, 16'h88B5, EtherType field.
- FRAME_WORDS, 16, 32-bit words per frame; legal range 5..1024, so minimum frame is 20 bytes.
- IFG_CYCLES, 12, idle cycles between frames.

Ports:
- axis_clk in 1: single clock for both the TX and RX sides.
- axis_reset in 1: synchronous, active-high reset.
- mtrlb_en in 1: enables frame generation.
- mtrlb_expect_swap in 1: when 1, RX expects DST and SRC swapped.
- m_axis_mtrlb_d_tdata out 32: TX data; byte 0 is in [7:0].
- m_axis_mtrlb_d_tkeep out 4: TX byte enables.
- m_axis_mtrlb_d_tvalid out 1.
- m_axis_mtrlb_d_tlast out 1.
- m_axis_mtrlb_d_tuser out 1.
- m_axis_mtrlb_d_tready in 1.
- s_axis_mtrlb_d_tdata in 32: returned frame data.
- s_axis_mtrlb_d_tkeep in 4.
- s_axis_mtrlb_d_tvalid in 1.
- s_axis_mtrlb_d_tlast in 1.
- s_axis_mtrlb_d_tuser in 1.
- s_axis_mtrlb_d_tready out 1.
- frames_tx_count out 32: completed TX frames.
- frames_rx_count out 32: RX frames seen, counted on each tlast beat.
- err_count out 16: RX frames with an error, saturating.
- mtrlb_activity_flash out 1: equals frames_rx_count[13].

Behaviour:
- Reset values (registered synchronously):
  - All TX AXIS outputs 0, s_axis_mtrlb_d_tready 0.
  - All counters 0; TX sequence and expected RX sequence 0.
  - TX FSM in IDLE; RX word index 0; RX error flag 0.
  - Reset asserted mid-frame aborts both directions immediately; no partial-frame accounting.
- Frame format (word w, byte b = tdata[8b+7:8b], network order):
  - w0: DST[47:16].
  - w1: DST[15:0], SRC[47:32].
  - w2: SRC[31:0].
  - w3: ETHERTYPE[15:8], ETHERTYPE[7:0], seq[15:8], seq[7:0].
  - w>=4: byte b = (4w+b) mod 256.
  - tkeep is always 4'hF; tuser is always 0; tlast is set only on w = FRAME_WORDS-1.
- TX FSM states:
  - IDLE: tvalid=0. If mtrlb_en=1, go to SEND with w=0; tvalid rises the cycle after en is sampled high.
  - SEND: tvalid=1. data/last are held stable while tready=0. Each tvalid&tready beat increments w.
  - SEND, last beat: seq++ (wraps 16'hFFFF->0), frames_tx_count++ (wraps), go to IFG with counter = IFG_CYCLES.
  - mtrlb_en deasserted mid-frame: the frame completes normally.
  - IFG: tvalid=0, counter decrements. At 0, go to SEND if mtrlb_en=1, else IDLE. With IFG_CYCLES=0, IFG lasts one cycle.
- RX checker:
  - s_axis_mtrlb_d_tready=1 every cycle after reset is released.
  - Beats are counted by word index r, which saturates at FRAME_WORDS.
  - Expected w0..w2 are as TX when mtrlb_expect_swap=0. When swap=1, SRC and DST are exchanged: w0 = SRC[47:16], w1 = SRC[15:0],DST[47:32], w2 = DST[31:0].
  - w3: the EtherType bytes must match. The received seq must equal the expected RX seq; on mismatch, flag an error. In all cases set expected RX seq = received seq + 1 at tlast.
  - Payload words are compared against the pattern.
  - A beat sets the frame error flag on any of:
    - data mismatch;
    - tkeep != 4'hF;
    - tlast with r != FRAME_WORDS-1 (early end);
    - beat with r >= FRAME_WORDS (frame too long; beats are consumed until tlast);
    - tuser=1 on the tlast beat.
  - On the tlast beat:
    - frames_rx_count++;
    - if the error flag is set, or the current beat itself errs, err_count++, saturating at 16'hFFFF;
    - clear the flag and set r=0.
  - Counter updates are visible the cycle after the tlast beat.
  - TX and RX operate independently; simultaneous TX last and RX last in one cycle are both counted.

Test Plan:
- mtrlb_en=1 for one frame, tready=1, FRAME_WORDS=16 -> 16 beats, w0=32'h0300350A? No: w0 = bytes 0A,35,00,01 = 32'h0100350A; w3 = 32'h0000B588; tlast on beat 16; frames_tx_count=1.
- Random tready backpressure (50%) -> data/last stable during stalls; payload byte sequence unbroken; 12 idle cycles between frames.
- TX looped to RX through a model swapping the first 12 bytes, expect_swap=1, 100 frames -> frames_rx_count=100, err_count=0, expected seq=100.
- Looped with expect_swap=0 and no swap -> err_count=0. Corrupt one payload byte in frame 5 -> err_count=1, no other frame affected.
- Drop frame 3 from the return path -> err_count=1 (seq mismatch on frame 4); frames 5 onward clean. Truncated 10-word frame -> err_count+1. Tuser=1 on a last beat -> err_count+1.
- Assert axis_reset mid-frame on both ports -> next cycle tvalid=0, tready=0, all counters 0; first frame after release carries seq=0 and checks clean.
